player_motion_anim: RTL and testbench
=====================================

// Module: player_motion_anim
// PURPOSE
//  Per-frame player controller upstream of the sprite renderers. Turns keyboard levels into the sprite
//  top-left position (PlayerX/PlayerY -> BallX/BallY of the renderer) plus facing and animation frame.
//  anim_frame selects idle / run1 / run2 / run3 ROM. State advances only on frame_tick (one pulse per
//  frame, issued during vertical blank), so outputs are constant during active video.
// PARAMETERS
//  X_START   100  reset X (top-left)
//  Y_GROUND  400  grounded Y (top-left)
//  X_MIN     0    leftmost legal X
//  X_MAX     639  rightmost screen pixel; X clamps to X_MAX-SPRITE_W+1
//  SPRITE_W  40   sprite width in pixels
//  X_STEP    2    horizontal pixels per tick
//  JUMP_VEL  12   takeoff upward speed (px/tick)
//  GRAVITY   1    added to vy each airborne tick
//  ANIM_DIV  4    ticks per run-animation step
// PORTS
//  vga_clk      in   1   pixel clock; only clock
//  Reset        in   1   synchronous, active-high
//  frame_tick   in   1   one-cycle pulse per frame (vblank)
//  key_left     in   1   level, move left
//  key_right    in   1   level, move right
//  key_jump     in   1   level, jump request (edge-qualified internally)
//  PlayerX      out  10  sprite top-left X
//  PlayerY      out  10  sprite top-left Y
//  facing_left  out  1   1 = mirror sprite
//  anim_frame   out  2   0 idle, 1..3 run1..run3
//  airborne     out  1   1 while in JUMP state
// BEHAVIOUR
//  Reset (priority over frame_tick): PlayerX=X_START, PlayerY=Y_GROUND, vy=0, facing_left=0,
//   anim_frame=0, airborne=0, state=IDLE, anim_cnt=0, jump_prev=0. All outputs registered.
//  Non-tick cycles: all state holds. Tick: updates visible on the edge after frame_tick is sampled.
//  dir: exactly one of left/right high -> move X_STEP that way, facing_left<=key_left.
//   Both or neither high -> no X motion, facing holds.
//  X clamp: X_new<X_MIN -> X_MIN; X_new>X_MAX-SPRITE_W+1 -> that limit. Compute in >=11b signed.
//  Jump edge: jump_go = key_jump & ~jump_prev. jump_prev <= key_jump each tick only (held key = one jump).
//  FSM (tick-driven):
//   IDLE: jump_go -> JUMP; else dir valid -> RUN; anim_frame=0, anim_cnt=0.
//   RUN : jump_go -> JUMP; else no dir -> IDLE (anim_frame=0); else anim_cnt++; at ANIM_DIV-1
//         wrap anim_cnt to 0 and step anim_frame 1->2->3->1. Entering RUN: anim_frame=1, anim_cnt=0.
//   JUMP: takeoff tick: Y=Y-JUMP_VEL, vy=-JUMP_VEL+GRAVITY. Later ticks: Y=Y+vy, vy=vy+GRAVITY.
//         If Y+vy >= Y_GROUND: Y=Y_GROUND, vy=0, exit to RUN (dir valid) else IDLE.
//         If Y+vy < 0: Y=0, vy=0 (then falls). anim_frame=1 while airborne. X motion allowed.
//  vy: 8b signed; saturate at +127.
//  Jump and direction on the same tick: both applied (X moves on takeoff tick).
//  Reset asserted mid-jump: returns to reset values next edge, no landing.
// TESTING
//  Reset, 3 ticks no keys -> X=100, Y=400, anim_frame=0, airborne=0.
//  key_right held 8 ticks -> X=116, facing_left=0, anim_frame 1,1,1,1,2,2,2,2 (cnt wraps at 3).
//  key_jump held 30 ticks -> Y=388,377..; Y=322 at tick 12; Y=400, airborne=0 at tick 25;
//   no 2nd jump until key_jump drops for >=1 tick.
//  key_left held 60 ticks from X=100 -> X clamps at 0; key_right from 598 -> clamps at 600.
//  Both keys held 5 ticks -> X unchanged, state IDLE, facing unchanged.
//  Reset pulse at tick 6 of jump -> next edge X=100, Y=400, airborne=0; frame_tick same cycle ignored.

Source files
------------

// File: rtl/player_motion_anim_if.sv
// Per-frame control bundle for the player controller: tick and key levels in,
// registered sprite position, facing and animation state out.
interface player_motion_anim_if;
    logic       frame_tick;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic [9:0] PlayerX;
    logic [9:0] PlayerY;
    logic       facing_left;
    logic [1:0] anim_frame;
    logic       airborne;

    modport master (
        output frame_tick, key_left, key_right, key_jump,
        input  PlayerX, PlayerY, facing_left, anim_frame, airborne
    );

    modport slave (
        input  frame_tick, key_left, key_right, key_jump,
        output PlayerX, PlayerY, facing_left, anim_frame, airborne
    );
endinterface

// File: rtl/player_motion_anim.sv
// Player controller: advances position, jump physics and run animation once per
// frame_tick so the renderer sees constant values throughout active video.
module player_motion_anim #(
    parameter int X_START  = 100,
    parameter int Y_GROUND = 400,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int SPRITE_W = 40,
    parameter int X_STEP   = 2,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int ANIM_DIV = 4
) (
    input  logic                 vga_clk,
    input  logic                 Reset,
    player_motion_anim_if.slave  bus
);

    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic signed [11:0] X_LO_S     = 12'(X_MIN);
    localparam logic signed [11:0] X_HI_S     = 12'(X_MAX - SPRITE_W + 1);
    localparam logic signed [11:0] X_STEP_S   = 12'(X_STEP);
    localparam logic signed [11:0] Y_GROUND_S = 12'(Y_GROUND);
    localparam logic signed [11:0] JUMP_VEL_S = 12'(JUMP_VEL);
    localparam logic signed [8:0]  GRAVITY_S  = 9'(GRAVITY);
    localparam logic signed [8:0]  VY_MAX_S   = 9'sd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_JUMP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [7:0]  vy_q, vy_d;
    logic               facing_q, facing_d;
    logic [1:0]         frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               air_q, air_d;
    logic               jump_prev_q, jump_prev_d;

    logic               dir_valid;
    logic               jump_go;
    logic signed [11:0] x_ext, x_next, x_clamped;
    logic signed [11:0] y_ext, y_sum, y_takeoff;
    logic signed [8:0]  vy_inc;
    logic signed [7:0]  vy_sat;

    assign dir_valid = bus.key_left ^ bus.key_right;
    assign jump_go   = bus.key_jump & ~jump_prev_q;

    // Position and velocity arithmetic is done in 12-bit signed so that
    // under/overflow past the screen edges is visible before clamping.
    always_comb begin
        x_ext  = signed'({2'b00, x_q});
        x_next = bus.key_left ? (x_ext - X_STEP_S) : (x_ext + X_STEP_S);
        if (x_next < X_LO_S) begin
            x_clamped = X_LO_S;
        end else if (x_next > X_HI_S) begin
            x_clamped = X_HI_S;
        end else begin
            x_clamped = x_next;
        end

        y_ext     = signed'({2'b00, y_q});
        y_sum     = y_ext + signed'({{4{vy_q[7]}}, vy_q});
        y_takeoff = y_ext - JUMP_VEL_S;

        vy_inc = signed'({vy_q[7], vy_q}) + GRAVITY_S;
        vy_sat = (vy_inc > VY_MAX_S) ? 8'sd127 : 8'(vy_inc);
    end

    always_comb begin
        // NOTE: every *_d defaults to its *_q first, so no path through the
        // case below leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        facing_d    = facing_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        air_d       = air_q;
        jump_prev_d = jump_prev_q;

        if (bus.frame_tick) begin
            jump_prev_d = bus.key_jump;

            if (dir_valid) begin
                x_d      = 10'(x_clamped);
                facing_d = bus.key_left;
            end

            unique case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (jump_go) begin
                        state_d = ST_JUMP;
                        y_d     = (y_takeoff < 12'sd0) ? 10'd0 : 10'(y_takeoff);
                        vy_d    = 8'(GRAVITY - JUMP_VEL);
                        frame_d = 2'd1;
                        cnt_d   = '0;
                        air_d   = 1'b1;
                    end else if (!dir_valid) begin
                        state_d = ST_IDLE;
                        frame_d = 2'd0;
                        cnt_d   = '0;
                    end else if (state_q == ST_IDLE) begin
                        state_d = ST_RUN;
                        frame_d = 2'd1;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                        cnt_d   = '0;
                        frame_d = (frame_q == 2'd3) ? 2'd1 : frame_q + 2'd1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end

                ST_JUMP: begin
                    if (y_sum >= Y_GROUND_S) begin
                        y_d     = 10'(Y_GROUND);
                        vy_d    = 8'sd0;
                        air_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = dir_valid ? ST_RUN : ST_IDLE;
                        frame_d = dir_valid ? 2'd1 : 2'd0;
                    end else if (y_sum < 12'sd0) begin
                        // Head hit the top of the screen: pin and start falling.
                        y_d  = 10'd0;
                        vy_d = 8'sd0;
                    end else begin
                        y_d  = 10'(y_sum);
                        vy_d = vy_sat;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    frame_d = 2'd0;
                    cnt_d   = '0;
                    air_d   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: Reset is synchronous and wins over frame_tick; all state uses
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            x_q         <= 10'(X_START);
            y_q         <= 10'(Y_GROUND);
            vy_q        <= 8'sd0;
            facing_q    <= 1'b0;
            frame_q     <= 2'd0;
            cnt_q       <= '0;
            air_q       <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            facing_q    <= facing_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            air_q       <= air_d;
            jump_prev_q <= jump_prev_d;
        end
    end

    assign bus.PlayerX     = x_q;
    assign bus.PlayerY     = y_q;
    assign bus.facing_left = facing_q;
    assign bus.anim_frame  = frame_q;
    assign bus.airborne    = air_q;

endmodule

// File: tb/tb_player_motion_anim.sv
// Self-checking bench for player_motion_anim: directed scenarios plus randomized
// key sequences compared against a frame-level behavioural model.
module tb_player_motion_anim;

    localparam int X_START  = 100;
    localparam int Y_GROUND = 400;
    localparam int X_LIMIT  = 639 - 40 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    player_motion_anim_if bus();

    player_motion_anim dut (
        .vga_clk (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: plain integers following the per-frame movement rules.
    int m_x, m_y, m_vy, m_frame, m_cnt;
    bit m_face, m_air, m_prev;

    task automatic model_reset();
        m_x = X_START; m_y = Y_GROUND; m_vy = 0;
        m_frame = 0; m_cnt = 0;
        m_face = 0; m_air = 0; m_prev = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        bit dir;
        bit go;
        int nx;
        dir = l ^ r;
        go  = j && !m_prev;
        m_prev = j;
        if (dir) begin
            nx = m_x + (l ? -2 : 2);
            if (nx < 0) nx = 0;
            if (nx > X_LIMIT) nx = X_LIMIT;
            m_x = nx;
            m_face = l;
        end
        if (!m_air) begin
            if (go) begin
                m_air = 1; m_y = m_y - 12; m_vy = -11; m_frame = 1; m_cnt = 0;
            end else if (!dir) begin
                m_frame = 0; m_cnt = 0;
            end else if (m_frame == 0) begin
                m_frame = 1; m_cnt = 0;
            end else if (m_cnt == 3) begin
                m_cnt = 0; m_frame = (m_frame % 3) + 1;
            end else begin
                m_cnt++;
            end
        end else begin
            if (m_y + m_vy >= Y_GROUND) begin
                m_y = Y_GROUND; m_vy = 0; m_air = 0; m_cnt = 0;
                m_frame = dir ? 1 : 0;
            end else if (m_y + m_vy < 0) begin
                m_y = 0; m_vy = 0;
            end else begin
                m_y = m_y + m_vy;
                m_vy = (m_vy + 1 > 127) ? 127 : m_vy + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.key_left = 1'b0; bus.key_right = 1'b0; bus.key_jump = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One frame: keys applied, frame_tick pulsed for one cycle, outputs sampled on the next negedge.
    task automatic do_tick(input bit l, input bit r, input bit j);
        @(negedge clk);
        bus.key_left = l; bus.key_right = r; bus.key_jump = j;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_tick(l, r, j);
    endtask

    task automatic test_reset();
        do_reset();
        for (int t = 1; t <= 3; t++) do_tick(0, 0, 0);
        n_cmp++;
        if (bus.PlayerX !== 10'd100) begin
            n_bad++; $display("FAIL reset_x: got %0d want 100", bus.PlayerX);
        end
        n_cmp++;
        if (bus.PlayerY !== 10'd400) begin
            n_bad++; $display("FAIL reset_y: got %0d want 400", bus.PlayerY);
        end
        n_cmp++;
        if (bus.anim_frame !== 2'd0 || bus.airborne !== 1'b0 || bus.facing_left !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got frame=%0d air=%0d face=%0d want 0/0/0",
                     bus.anim_frame, bus.airborne, bus.facing_left);
        end
    endtask

    task automatic test_run_right();
        int exp_frame [8] = '{1, 1, 1, 1, 2, 2, 2, 2};
        do_reset();
        for (int t = 0; t < 8; t++) begin
            do_tick(0, 1, 0);
            n_cmp++;
            if (bus.anim_frame !== 2'(exp_frame[t]) || bus.PlayerX !== 10'(m_x)) begin
                n_bad++;
                $display("FAIL run_right tick %0d: got frame=%0d x=%0d want frame=%0d x=%0d",
                         t + 1, bus.anim_frame, bus.PlayerX, exp_frame[t], m_x);
            end
        end
        n_cmp++;
        if (bus.PlayerX !== 10'd116 || bus.facing_left !== 1'b0) begin
            n_bad++;
            $display("FAIL run_right_final: got x=%0d face=%0d want x=116 face=0",
                     bus.PlayerX, bus.facing_left);
        end
    endtask

    task automatic test_jump();
        int fixed_y;
        do_reset();
        for (int t = 1; t <= 30; t++) begin
            do_tick(0, 0, 1);
            n_cmp++;
            if (bus.PlayerY !== 10'(m_y) || bus.airborne !== m_air || bus.anim_frame !== 2'(m_frame)) begin
                n_bad++;
                $display("FAIL jump tick %0d: got y=%0d air=%0d frame=%0d want y=%0d air=%0d frame=%0d",
                         t, bus.PlayerY, bus.airborne, bus.anim_frame, m_y, m_air, m_frame);
            end
            fixed_y = -1;
            if (t == 1)  fixed_y = 388;
            if (t == 2)  fixed_y = 377;
            if (t == 12) fixed_y = 322;
            if (t == 25) fixed_y = 400;
            if (fixed_y >= 0) begin
                n_cmp++;
                if (bus.PlayerY !== 10'(fixed_y)) begin
                    n_bad++;
                    $display("FAIL jump_y_t%0d: got %0d want %0d", t, bus.PlayerY, fixed_y);
                end
            end
            if (t >= 25) begin
                n_cmp++;
                if (bus.airborne !== 1'b0) begin
                    n_bad++;
                    $display("FAIL jump_held_no_rejump t%0d: got air=%0d want 0", t, bus.airborne);
                end
            end
        end
        do_tick(0, 0, 0);
        do_tick(0, 0, 1);
        n_cmp++;
        if (bus.airborne !== 1'b1 || bus.PlayerY !== 10'd388) begin
            n_bad++;
            $display("FAIL jump_retrigger: got air=%0d y=%0d want air=1 y=388",
                     bus.airborne, bus.PlayerY);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int t = 0; t < 60; t++) do_tick(1, 0, 0);
        n_cmp++;
        if (bus.PlayerX !== 10'd0 || bus.facing_left !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_left: got x=%0d face=%0d want x=0 face=1", bus.PlayerX, bus.facing_left);
        end
        for (int t = 0; t < 299; t++) do_tick(0, 1, 0);
        n_cmp++;
        if (bus.PlayerX !== 10'd598) begin
            n_bad++; $display("FAIL clamp_pre_right: got x=%0d want 598", bus.PlayerX);
        end
        for (int t = 0; t < 3; t++) begin
            do_tick(0, 1, 0);
            n_cmp++;
            if (bus.PlayerX !== 10'd600) begin
                n_bad++; $display("FAIL clamp_right t%0d: got x=%0d want 600", t, bus.PlayerX);
            end
        end
    endtask

    task automatic test_both_keys();
        do_reset();
        do_tick(1, 0, 0);
        for (int t = 0; t < 5; t++) begin
            do_tick(1, 1, 0);
            n_cmp++;
            if (bus.PlayerX !== 10'd98 || bus.anim_frame !== 2'd0 || bus.facing_left !== 1'b1) begin
                n_bad++;
                $display("FAIL both_keys t%0d: got x=%0d frame=%0d face=%0d want x=98 frame=0 face=1",
                         t, bus.PlayerX, bus.anim_frame, bus.facing_left);
            end
        end
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        for (int t = 0; t < 5; t++) do_tick(0, 1, 1);
        n_cmp++;
        if (bus.airborne !== 1'b1 || bus.PlayerX !== 10'd110) begin
            n_bad++;
            $display("FAIL mid_jump_pre: got air=%0d x=%0d want air=1 x=110", bus.airborne, bus.PlayerX);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        bus.key_right = 1'b0; bus.key_jump = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.PlayerX !== 10'd100 || bus.PlayerY !== 10'd400 || bus.airborne !== 1'b0 ||
            bus.anim_frame !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_jump_reset: got x=%0d y=%0d air=%0d frame=%0d want 100/400/0/0",
                     bus.PlayerX, bus.PlayerY, bus.airborne, bus.anim_frame);
        end
    endtask

    task automatic test_random();
        bit l, r, j;
        int gap;
        do_reset();
        l = 0; r = 0; j = 0;
        for (int t = 0; t < 400; t++) begin
            if ((t % 6) == 0) begin
                l = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    l = ~l; r = ~r;
                end
            end
            j = ($urandom_range(0, 9) < 2);
            do_tick(l, r, j);
            n_cmp++;
            if (bus.PlayerX !== 10'(m_x) || bus.PlayerY !== 10'(m_y) || bus.facing_left !== m_face ||
                bus.anim_frame !== 2'(m_frame) || bus.airborne !== m_air) begin
                n_bad++;
                $display("FAIL random t%0d: got x=%0d y=%0d f=%0d fr=%0d a=%0d want x=%0d y=%0d f=%0d fr=%0d a=%0d",
                         t, bus.PlayerX, bus.PlayerY, bus.facing_left, bus.anim_frame, bus.airborne,
                         m_x, m_y, m_face, m_frame, m_air);
            end
            if ((t % 25) == 0) begin
                gap = $urandom_range(1, 4);
                for (int g = 0; g < gap; g++) @(negedge clk);
                n_cmp++;
                if (bus.PlayerX !== 10'(m_x) || bus.PlayerY !== 10'(m_y) || bus.anim_frame !== 2'(m_frame)) begin
                    n_bad++;
                    $display("FAIL hold_between_ticks t%0d: got x=%0d y=%0d fr=%0d want x=%0d y=%0d fr=%0d",
                             t, bus.PlayerX, bus.PlayerY, bus.anim_frame, m_x, m_y, m_frame);
                end
            end
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.key_left = 1'b0; bus.key_right = 1'b0; bus.key_jump = 1'b0;
        model_reset();
        test_reset();
        test_run_right();
        test_jump();
        test_clamp();
        test_both_keys();
        test_reset_mid_jump();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
